convolutor_z_reader: RTL and testbench

- Read-side engine for the convolution coprocessor's result memory (Z RAM, 16-bit x 64).
- After the convolutor finishes, it walks Z RAM addresses 0..N-1 through the RAM's synchronous read port.
- Each result is presented on a valid/ready output stream toward the host.
- A 2-entry output buffer absorbs the 1-cycle RAM read latency, so the stream sustains one beat per cycle and tolerates arbitrary backpressure without losing or duplicating data.

---
 rtl/convolutor_z_reader.sv | 150 +++++++++++++++
 tb/tb_convolutor_z_reader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/convolutor_z_reader.sv
// Z RAM read-out engine: walks addresses 0..N-1 through the synchronous read port and
// streams each word on a valid/ready interface, with a 2-entry buffer covering read latency.
//
// state  | meaning
// S_IDLE | waiting for start_i; count_i latched on start
// S_RUN  | issuing reads and streaming beats until N beats accepted
// S_DONE | one-cycle done_o pulse, start_i ignored
module convolutor_z_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   count_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]         n_q;
  logic [CW-1:0]         issued_q;
  logic [CW-1:0]         accepted_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  inflight_q;

  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [1:0]            buf_count_q;

  logic start_accept;
  logic push;
  logic pop;
  logic issue;
  logic last_accept;
  logic room;

  assign start_accept = (state_q == S_IDLE) && start_i;
  assign push         = inflight_q;
  assign pop          = m_valid_o && m_ready_i;
  assign room         = ({1'b0, buf_count_q} + {2'b00, inflight_q}) < 3'd2;
  // A beat leaving this cycle frees a slot, so a full buffer can still issue.
  assign issue        = (state_q == S_RUN) && (issued_q < n_q) && (room || pop);
  assign last_accept  = (state_q == S_RUN) && pop && (accepted_q == n_q - CNT_ONE);

  assign mem_addr_o = addr_q;
  assign m_valid_o  = (buf_count_q != 2'd0);
  assign m_data_o   = m_valid_o ? buf_q[rd_ptr_q] : '0;
  assign m_last_o   = m_valid_o && (accepted_q == n_q - CNT_ONE);
  assign busy_o     = (state_q == S_RUN);
  assign done_o     = (state_q == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = (count_i == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_accept) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q        <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
    end else if (start_accept) begin
      n_q        <= count_i;
      issued_q   <= '0;
      accepted_q <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        issued_q <= issued_q + CNT_ONE;
        // Hold the address on the final read so a full 64-word pass never wraps to 0.
        if (issued_q != n_q - CNT_ONE) begin
          addr_q <= addr_q + ADDR_WIDTH'(1);
        end
      end
      if (pop) begin
        accepted_q <= accepted_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      buf_count_q <= 2'd0;
    end else begin
      if (push) begin
        buf_q[wr_ptr_q] <= mem_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   buf_count_q <= buf_count_q + 2'd1;
        2'b01:   buf_count_q <= buf_count_q - 2'd1;
        default: buf_count_q <= buf_count_q;
      endcase
    end
  end

  buf_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (buf_count_q == 2'd2)));

endmodule

// File: tb/tb_convolutor_z_reader.sv
// Randomised and directed bench for convolutor_z_reader against a stream-level model:
// each read-out of N words must deliver Z[0..N-1] in order, with last on Z[N-1] and one done pulse.
module tb_convolutor_z_reader;
  localparam int DW = 16;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [AW:0]   count_i = '0;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_i;
  logic [DW-1:0] m_data_o;
  logic          m_valid_o;
  logic          m_ready_i = 1'b0;
  logic          m_last_o;
  logic          busy_o;
  logic          done_o;

  logic [DW-1:0] zram [64];
  int n_checks = 0;
  int n_pass = 0;

  convolutor_z_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .count_i(count_i),
    .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_last_o(m_last_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_data_i <= zram[mem_addr_o];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Stream-level model: whether a read-out is active, which word is due next, done pending.
  bit            md_active = 0;
  bit            md_done = 0;
  int            md_n = 0;
  int            md_idx = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_valid", m_valid_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_addr", mem_addr_o, 0);
      md_active  = 0;
      md_done    = 0;
      prev_stall = 0;
    end else begin
      check("done_o", done_o, md_done);
      check("busy_o", busy_o, md_active);
      if (prev_stall) begin
        check("hold_valid", m_valid_o, 1);
        check("hold_data", m_data_o, prev_data);
      end
      if (md_active) begin
        check("addr_lead", (int'(mem_addr_o) <= md_idx + 2), 1);
        check("addr_range", (int'(mem_addr_o) < md_n), 1);
        if (m_valid_o) begin
          check("beat_data", m_data_o, zram[md_idx]);
          check("beat_last", m_last_o, (md_idx == md_n - 1));
        end
      end else begin
        check("idle_valid", m_valid_o, 0);
      end
      prev_stall = m_valid_o && !m_ready_i;
      prev_data  = m_data_o;
      if (md_done) begin
        md_done = 0;
      end else if (!md_active) begin
        if (start_i) begin
          md_n   = int'(count_i);
          md_idx = 0;
          if (md_n == 0) md_done = 1;
          else md_active = 1;
        end
      end else if (m_valid_o && m_ready_i) begin
        md_idx++;
        if (md_idx == md_n) begin
          md_active = 0;
          md_done   = 1;
        end
      end
    end
  end

  function automatic bit ready_for(input int mode, input int c);
    int ph;
    ph = c % 4;
    if (mode == 0) return 1'b1;
    if (mode == 1) return (ph == 0) || (ph == 3);
    return 1'($urandom_range(1, 0));
  endfunction

  // cyc counts edges after the start edge (0 = cycle right after start is sampled).
  task automatic run(input int n, input int mode, input bit hold,
                     output int first_v, output int done_c, output int beats, output int lasts,
                     output logic [DW-1:0] d_first, output logic [DW-1:0] d_last,
                     output bit addr_ok);
    int cyc;
    bit seen_done;
    cyc = -1; seen_done = 0;
    first_v = -1; done_c = -1; beats = 0; lasts = 0; addr_ok = 1;
    d_first = '0; d_last = '0;
    @(posedge clk); #1;
    start_i = 1'b1; count_i = (AW + 1)'(n); m_ready_i = ready_for(mode, 0);
    for (int t = 0; t < 400 && !seen_done; t++) begin
      @(posedge clk); cyc++; #1;
      if (!hold) start_i = 1'b0;
      m_ready_i = ready_for(mode, cyc);
      @(negedge clk);
      if (mode == 0 && n > 0 && cyc <= n && int'(mem_addr_o) != ((cyc < n) ? cyc : n - 1)) addr_ok = 0;
      if (m_valid_o && first_v < 0) first_v = cyc;
      if (m_valid_o && m_ready_i) begin
        beats++;
        if (beats == 1) d_first = m_data_o;
        d_last = m_data_o;
        if (m_last_o) lasts++;
      end
      if (done_o) begin
        done_c = cyc;
        seen_done = 1;
      end
    end
    check("done_seen", seen_done, 1);
    @(posedge clk); #1;
    start_i = 1'b0; m_ready_i = 1'b0;
  endtask

  int fv, dc, bt, ls, acc;
  logic [DW-1:0] df, dl;
  bit aok;
  int rn;

  initial begin
    for (int k = 0; k < 64; k++) zram[k] = DW'(k * 3);
    repeat (3) @(negedge clk);
    check("init_data", m_data_o, 0);
    check("init_last", m_last_o, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Full-rate read-out of 10 words
    run(10, 0, 0, fv, dc, bt, ls, df, dl, aok);
    check("t1_first_valid_cyc", fv, 2);
    check("t1_done_cyc", dc, 12);
    check("t1_beats", bt, 10);
    check("t1_lasts", ls, 1);
    check("t1_first_data", df, 16'd0);
    check("t1_last_data", dl, 16'd27);
    check("t1_addr_seq", aok, 1);
    @(negedge clk);
    check("t1_busy_after", busy_o, 0);

    // Backpressure pattern 1,0,0,1
    run(10, 1, 0, fv, dc, bt, ls, df, dl, aok);
    check("t2_beats", bt, 10);
    check("t2_lasts", ls, 1);
    check("t2_last_data", dl, 16'd27);

    // Zero-length read-out
    run(0, 0, 0, fv, dc, bt, ls, df, dl, aok);
    check("t3_no_valid", fv, -1);
    check("t3_beats", bt, 0);
    check("t3_done_cyc", dc, 0);
    check("t3_addr", mem_addr_o, 0);

    // Full depth, no wrap
    for (int k = 0; k < 64; k++) zram[k] = 16'hA500 + DW'(k);
    run(64, 0, 0, fv, dc, bt, ls, df, dl, aok);
    check("t4_beats", bt, 64);
    check("t4_first_data", df, 16'hA500);
    check("t4_last_data", dl, 16'hA53F);
    check("t4_addr_seq", aok, 1);
    check("t4_done_cyc", dc, 66);
    check("t4_last_addr", mem_addr_o, 63);

    // Reset with 3 beats remaining, 2 buffered
    for (int k = 0; k < 64; k++) zram[k] = DW'(k * 3);
    @(posedge clk); #1;
    start_i = 1'b1; count_i = 7'd10; m_ready_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    acc = 0;
    for (int t = 0; t < 60 && acc < 7; t++) begin
      @(negedge clk);
      if (m_valid_o && m_ready_i) acc++;
      @(posedge clk); #1;
      m_ready_i = (acc < 7);
    end
    check("t5_accepted_before_rst", acc, 7);
    repeat (4) @(posedge clk);
    #2;
    check("t5_valid_before_rst", m_valid_o, 1);
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", m_valid_o, 0);
    check("t5_async_busy", busy_o, 0);
    check("t5_async_data", m_data_o, 0);
    check("t5_async_addr", mem_addr_o, 0);
    @(negedge clk);
    @(posedge clk); #3 rst_n = 1'b1;
    run(4, 0, 0, fv, dc, bt, ls, df, dl, aok);
    check("t5_beats", bt, 4);
    check("t5_first_data", df, 16'd0);
    check("t5_last_data", dl, 16'd9);
    check("t5_lasts", ls, 1);

    // start_i held through read-out and DONE
    run(5, 0, 1, fv, dc, bt, ls, df, dl, aok);
    check("t6_beats", bt, 5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_single_readout", busy_o, 0);
    end

    // Random data, lengths and backpressure
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 64; k++) zram[k] = DW'($urandom);
      rn = int'($urandom_range(64, 1));
      run(rn, 2, 0, fv, dc, bt, ls, df, dl, aok);
      check("rnd_beats", bt, rn);
      check("rnd_lasts", ls, 1);
      check("rnd_last_data", dl, zram[rn - 1]);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
